// File: rtl/rr_arbiter4_pkg.sv
// Shared types and helpers for the 4-way round-robin arbiter.
//   NUM_REQ  : number of requesters
//   ID_W     : width of a requester index
//   state_t  : arbiter FSM encoding
//   pick_t   : result of a round-robin search {found, id}
//   rr_pick  : round-robin search starting one past 'last', skipping 'mask' bits
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic            found;
    logic [ID_W-1:0] id;
  } pick_t;

  // Candidates are visited in order last+1, last+2, ... wrapping; last itself
  // is visited at the end, so it only wins when nobody else is requesting.
  function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                    input logic [ID_W-1:0]    last,
                                    input logic [NUM_REQ-1:0] mask);
    pick_t                p;
    logic [NUM_REQ-1:0]   avail;
    logic [ID_W-1:0]      idx;
    p     = '0;
    avail = req & ~mask;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = last + ID_W'(i);
      if (!p.found && avail[idx]) begin
        p.found = 1'b1;
        p.id    = idx;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between the requesting units and the arbiter.
//   req      : per-requester level request
//   done     : per-requester release strobe (only the holder's bit matters)
//   grant    : one-hot grant, zero when idle
//   grant_id : index of the current holder, meaningful while busy=1
//   busy     : a grant is active
//   timeout  : one-cycle pulse on a forced release
// Modports: master = requester side, slave = arbiter side.
interface rr_arbiter4_if;
  import arb_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] done;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               busy;
  logic               timeout;

  modport master (
    output req, done,
    input  grant, grant_id, busy, timeout
  );

  modport slave (
    input  req, done,
    output grant, grant_id, busy, timeout
  );

endinterface

// File: rtl/rr_arbiter4_dec.sv
// Decoder2to4: 2-bit index to one-hot with enable.
//   in  : index
//   e   : enable; output is all zeros when low
//   out : one-hot result
module Decoder2to4 (
  input  logic [1:0] in,
  input  logic       e,
  output logic [3:0] out
);

  assign out = e ? (4'b0001 << in) : 4'b0000;

endmodule

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: round-robin arbiter sharing one resource among 4 requesters.
// A grant is held until the holder strobes done or drops its request; priority
// then rotates to the requester after the holder. The one-hot grant bus is
// decoded from the registered holder index, so it never carries two bits.
//   clk    : clock, rising edge
//   reset  : synchronous, active-high
//   bus    : rr_arbiter4_if.slave (req, done in; grant, grant_id, busy, timeout out)
// Optional feature: define ARB_TIMEOUT_EN to add a hold counter that forces a
// release after MAX_HOLD cycles (MAX_HOLD 1..15, only exists with the macro).
// Without it timeout is tied low and a grant is held indefinitely.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   ST_IDLE  | no holder; arbitrate over req each cycle
//   ST_GRANT | grant_id holds the resource until release
module rr_arbiter4
  import arb_pkg::*;
`ifdef ARB_TIMEOUT_EN
  #(parameter int MAX_HOLD = 15)
`endif
(
  input logic          clk,
  input logic          reset,
  rr_arbiter4_if.slave bus
);

  state_t          state;
  logic [ID_W-1:0] last;
  logic [ID_W-1:0] grant_id;
  logic            busy;
  pick_t           pick;
  logic            norm_rel;
  logic            force_rel;
  logic            rel;

`ifdef ARB_TIMEOUT_EN
  logic [3:0] hold_cnt;
  logic       timeout;

  assign force_rel   = (hold_cnt == 4'(MAX_HOLD - 1));
  assign bus.timeout = timeout;
`else
  assign force_rel   = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  // While granted, the holder is masked out so a releasing requester cannot
  // re-win in its own release cycle; searching from grant_id matches the
  // update of last to grant_id on that same edge.
  always_comb begin
    pick = '0;
    if (state == ST_IDLE) pick = rr_pick(bus.req, last, '0);
    else                  pick = rr_pick(bus.req, grant_id, NUM_REQ'(1) << grant_id);
  end

  assign norm_rel = bus.done[grant_id] || !bus.req[grant_id];
  assign rel      = norm_rel || force_rel;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      last     <= 2'b11;
      grant_id <= 2'b00;
`ifdef ARB_TIMEOUT_EN
      hold_cnt <= 4'd0;
      timeout  <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (pick.found) begin
            state    <= ST_GRANT;
            grant_id <= pick.id;
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= 4'd0;
`endif
          end
        end
        ST_GRANT: begin
          if (rel) begin
            last <= grant_id;
`ifdef ARB_TIMEOUT_EN
            timeout  <= !norm_rel;
            hold_cnt <= 4'd0;
`endif
            if (pick.found) grant_id <= pick.id;
            else            state    <= ST_IDLE;
          end else begin
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= hold_cnt + 4'd1;
`endif
          end
        end
      endcase
    end
  end

  assign busy         = (state == ST_GRANT);
  assign bus.busy     = busy;
  assign bus.grant_id = grant_id;

  Decoder2to4 u_dec (
    .in  (grant_id),
    .e   (busy),
    .out (bus.grant)
  );

endmodule
